// File: rtl/fifo_push_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and helpers for the FIFO push-side round-robin arbiter.
//   state_t  : arbiter FSM state (IDLE / GRANT)
//   bcnt_w() : width of the burst counter for a given MAX_BURST
//   rr_next(): round-robin winner search used by rr_pick
// No ports (package). Optional statistics are enabled in the top-level
// module with the FIFO_ARB_STATS_EN macro.
// ----------------------------------------------------------------------------
package fifo_arb_pkg;

    localparam int MAX_REQ = 16;   // largest supported requester count
    localparam int STAT_W  = 16;   // width of each statistics counter

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // The burst counter must be able to hold MAX_BURST itself, hence the +1.
    function automatic int bcnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    // Search upward (with wrap) from last+1 for the first set request bit.
    // Only the low n bits of req are meaningful. Returns 0 when nothing is set;
    // callers qualify the result with an "any request" flag.
    function automatic int rr_next(input logic [MAX_REQ-1:0] req,
                                   input logic [3:0]         last,
                                   input int                 n);
        int   win;
        int   idx;
        logic found;
        win   = 0;
        found = 1'b0;
        for (int off = 1; off <= MAX_REQ; off++) begin
            if (!found && (off <= n)) begin
                idx = (int'(last) + off) % n;
                if (req[idx[3:0]]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// ----------------------------------------------------------------------------
// fifo_push_arbiter_if
// Bundles the producer handshakes and the FIFO push port of the arbiter.
//   req_valid/req_data/req_ready : per-requester valid/ready channels
//                                  (requester i data at [i*DATA_W +: DATA_W])
//   fifo_full/push_en/fifo_din   : FIFO push side
//   grant/busy                   : one-hot current owner, GRANT-state flag
// Modports: master = producers + FIFO (drive requests and full),
//           slave  = arbiter.
//
// Handshake: a word moves on a clock edge where valid and ready are both high.
// A producer keeps valid and data stable until it sees ready; ready may depend
// combinationally on fifo_full, valid never depends on ready.
// ----------------------------------------------------------------------------
interface fifo_push_arbiter_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      push_en;
    logic [DATA_W-1:0]         fifo_din;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;

    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, push_en, fifo_din, grant, busy
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, push_en, fifo_din, grant, busy
    );
endinterface

// File: rtl/fifo_push_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker.
//   i_req    : request vector
//   i_last   : index of the previous owner (search starts at i_last+1)
//   o_winner : index of the chosen requester (valid only when o_any)
//   o_any    : at least one request is set
// ----------------------------------------------------------------------------
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any
);

    logic [MAX_REQ-1:0] w_req_ext;
    logic [3:0]         w_last_ext;

    always_comb begin
        w_req_ext                = '0;
        w_req_ext[NUM_REQ-1:0]   = i_req;
        w_last_ext               = '0;
        w_last_ext[IDX_W-1:0]    = i_last;
    end

    assign o_winner = IDX_W'(rr_next(w_req_ext, w_last_ext, NUM_REQ));
    assign o_any    = |i_req;

endmodule

// File: rtl/fifo_push_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_push_arbiter
// Round-robin, burst-locking arbiter sharing one FIFO push port among
// NUM_REQ producers. An owner keeps the grant for up to MAX_BURST words or
// until it drops valid; a full FIFO stalls the owner without releasing it.
// Every arbitration costs exactly one IDLE bubble cycle.
//   clk, rst      : clock, synchronous active-high reset
//   arb_bus       : fifo_push_arbiter_if.slave (requests, FIFO push, grant)
//   o_dbg_state   : current FSM state
//   o_stat_cnt    : (FIFO_ARB_STATS_EN) per-requester accepted-word counters,
//                   requester i at [i*16 +: 16], saturating
//   o_stall_cnt   : (FIFO_ARB_STATS_EN) GRANT cycles with owner valid while
//                   the FIFO is full, saturating
// Build option: define FIFO_ARB_STATS_EN to add the statistics counters.
// ----------------------------------------------------------------------------
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    fifo_push_arbiter_if.slave        arb_bus,
`ifdef FIFO_ARB_STATS_EN
    output logic [NUM_REQ*STAT_W-1:0] o_stat_cnt,
    output logic [STAT_W-1:0]         o_stall_cnt,
`endif
    output state_t                    o_dbg_state
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BCNT_W = bcnt_w(MAX_BURST);

    state_t             r_state;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_last_owner;
    logic [BCNT_W-1:0]  r_burst_cnt;

    logic [IDX_W-1:0]   w_winner;
    logic               w_any;
    logic               w_owner_valid;
    logic               w_xfer;
    logic               w_last_word;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_ready;
    logic [DATA_W-1:0]  w_din;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req    (arb_bus.req_valid),
        .i_last   (r_last_owner),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    assign w_owner_valid = arb_bus.req_valid[r_owner];
    assign w_xfer        = (r_state == GRANT) && w_owner_valid && !arb_bus.fifo_full;
    assign w_last_word   = (r_burst_cnt == BCNT_W'(MAX_BURST - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_last_owner <= IDX_W'(NUM_REQ - 1);  // requester 0 wins first
            r_burst_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner     <= w_winner;
                        r_burst_cnt <= '0;
                        r_state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!w_owner_valid) begin
                        // Owner withdrew: nothing was transferred, release.
                        r_state      <= IDLE;
                        r_last_owner <= r_owner;
                    end else if (w_xfer) begin
                        if (r_burst_cnt != BCNT_W'(MAX_BURST))
                            r_burst_cnt <= r_burst_cnt + BCNT_W'(1);
                        if (w_last_word) begin
                            r_state      <= IDLE;
                            r_last_owner <= r_owner;
                        end
                    end
                    // Owner valid but FIFO full: hold everything.
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs decode the registered owner/state; ready follows fifo_full
    // combinationally so a stalled owner sees ready drop in the same cycle.
    always_comb begin
        w_grant = '0;
        w_ready = '0;
        w_din   = '0;
        if (r_state == GRANT) begin
            w_grant[r_owner] = 1'b1;
            w_ready[r_owner] = !arb_bus.fifo_full;
            w_din            = arb_bus.req_data[int'(r_owner)*DATA_W +: DATA_W];
        end
    end

    assign arb_bus.grant     = w_grant;
    assign arb_bus.req_ready = w_ready;
    assign arb_bus.fifo_din  = w_din;
    assign arb_bus.push_en   = w_xfer;
    assign arb_bus.busy      = (r_state == GRANT);
    assign o_dbg_state       = r_state;

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_W-1:0] r_stat_cnt;
    logic [STAT_W-1:0]              r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_xfer && (r_stat_cnt[r_owner] != {STAT_W{1'b1}}))
                r_stat_cnt[r_owner] <= r_stat_cnt[r_owner] + STAT_W'(1);
            if ((r_state == GRANT) && w_owner_valid && arb_bus.fifo_full &&
                (r_stall_cnt != {STAT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + STAT_W'(1);
        end
    end

    assign o_stat_cnt  = r_stat_cnt;
    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_push_arbiter
// Self-checking bench for fifo_push_arbiter: directed vector table, a few
// multi-cycle corner sequences, then randomized traffic against a
// transaction-level model of the arbitration rules.
// ----------------------------------------------------------------------------
module tb_fifo_push_arbiter;
    import fifo_arb_pkg::*;

    localparam int DATA_W    = 32;
    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_push_arbiter_if #(.DATA_W(DATA_W), .NUM_REQ(NUM_REQ)) bus ();
    state_t dbg_state;
`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] stat_cnt;
    logic [15:0]           stall_cnt;
`endif

    fifo_push_arbiter #(
        .DATA_W    (DATA_W),
        .NUM_REQ   (NUM_REQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arb_bus     (bus),
`ifdef FIFO_ARB_STATS_EN
        .o_stat_cnt  (stat_cnt),
        .o_stall_cnt (stall_cnt),
`endif
        .o_dbg_state (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks who owns the port and how many words they have pushed.
    bit  m_owned;
    int  m_owner;
    int  m_last;
    int  m_words;
    int  m_stat [NUM_REQ];
    int  m_stall;

    logic [DATA_W-1:0] exp_q[$];

    task automatic model_reset();
        m_owned = 0;
        m_owner = 0;
        m_last  = NUM_REQ - 1;
        m_words = 0;
        m_stall = 0;
        for (int i = 0; i < NUM_REQ; i++) m_stat[i] = 0;
    endtask

    function automatic int m_pick(input logic [NUM_REQ-1:0] v);
        for (int off = 1; off <= NUM_REQ; off++)
            if (v[(m_last + off) % NUM_REQ]) return (m_last + off) % NUM_REQ;
        return -1;
    endfunction

    // Values sampled at the last check point, for the directed sequences.
    logic               s_push;
    logic               s_busy;
    logic [NUM_REQ-1:0] s_grant;
    logic [NUM_REQ-1:0] s_ready;

    // Table row currently being applied (checked only when row_on).
    typedef struct packed {
        logic               rst;
        logic [NUM_REQ-1:0] valid;
        logic               full;
        logic [NUM_REQ-1:0] e_grant;
        logic               e_busy;
        logic               e_push;
        logic [NUM_REQ-1:0] e_ready;
    } row_t;

    bit   row_on = 0;
    row_t cur_row;

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic [NUM_REQ-1:0] v, input logic f);
        rst           = r;
        bus.req_valid = v;
        bus.fifo_full = f;
        for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_W +: DATA_W] = $urandom;
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model.
    task automatic step();
        logic [NUM_REQ-1:0] e_grant;
        logic [NUM_REQ-1:0] e_ready;
        logic               e_push;
        logic [DATA_W-1:0]  e_din;
        @(negedge clk);
        e_grant = '0;
        e_ready = '0;
        e_push  = 1'b0;
        e_din   = '0;
        if (m_owned) begin
            e_grant[m_owner] = 1'b1;
            e_ready[m_owner] = !bus.fifo_full;
            e_push           = bus.req_valid[m_owner] && !bus.fifo_full;
            e_din            = bus.req_data[m_owner*DATA_W +: DATA_W];
        end
        chk("grant",     bus.grant,     e_grant);
        chk("busy",      bus.busy,      m_owned);
        chk("push_en",   bus.push_en,   e_push);
        chk("req_ready", bus.req_ready, e_ready);
        chk("fifo_din",  bus.fifo_din,  e_din);
        chk("dbg_state", dbg_state,     m_owned);
        if (e_push) exp_q.push_back(e_din);
        if (bus.push_en) begin
            if (exp_q.size() > 0) chk("sb_data", bus.fifo_din, exp_q.pop_front());
            else                  chk("sb_spurious_push", bus.push_en, 1'b0);
        end
        if (row_on) begin
            chk("row_grant", bus.grant,     cur_row.e_grant);
            chk("row_busy",  bus.busy,      cur_row.e_busy);
            chk("row_push",  bus.push_en,   cur_row.e_push);
            chk("row_ready", bus.req_ready, cur_row.e_ready);
        end
        s_push  = bus.push_en;
        s_busy  = bus.busy;
        s_grant = bus.grant;
        s_ready = bus.req_ready;

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (m_owned) begin
            if (bus.req_valid[m_owner] && bus.fifo_full && m_stall < 16'hFFFF) m_stall++;
            if (!bus.req_valid[m_owner]) begin
                m_owned = 0;
                m_last  = m_owner;
            end else if (!bus.fifo_full) begin
                if (m_stat[m_owner] < 16'hFFFF) m_stat[m_owner]++;
                m_words++;
                if (m_words == MAX_BURST) begin
                    m_owned = 0;
                    m_last  = m_owner;
                end
            end
        end else if (bus.req_valid != '0) begin
            m_owner = m_pick(bus.req_valid);
            m_owned = 1;
            m_words = 0;
        end
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    row_t rows [19];
    int   k;
    int   pushes;

    initial begin
        rows[0]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000};
        rows[1]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000};
        rows[2]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000};
        rows[3]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000};
        rows[4]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100};
        rows[5]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100};
        rows[6]  = '{1'b0, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b0, 4'b0100};
        rows[7]  = '{1'b0, 4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000};
        rows[8]  = '{1'b0, 4'b1001, 1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000};
        rows[9]  = '{1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, 1'b0, 4'b0000};
        rows[10] = '{1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, 1'b0, 4'b0000};
        rows[11] = '{1'b0, 4'b1001, 1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000};
        rows[12] = '{1'b0, 4'b1001, 1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000};
        rows[13] = '{1'b0, 4'b1001, 1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000};
        rows[14] = '{1'b0, 4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000};
        rows[15] = '{1'b0, 4'b1001, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001};
        rows[16] = '{1'b1, 4'b1001, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001};
        rows[17] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000};
        rows[18] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001};

        // Initial reset.
        drive(1'b1, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Idle with no requests: nothing granted or pushed.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, '0, 1'b0);
            step();
            chk("idle_grant", s_grant, '0);
            chk("idle_push",  s_push,  1'b0);
        end

        // Directed vector table.
        for (int i = 0; i < 19; i++) begin
            cur_row = rows[i];
            row_on  = 1;
            drive(cur_row.rst, cur_row.valid, cur_row.full);
            step();
        end
        row_on = 0;

        // Fairness: all valid, 16 words in 20 cycles, owners 0,1,2,3 in order.
        drive(1'b1, 4'b1111, 1'b0);
        step();
        k = 0;
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 4'b1111, 1'b0);
            step();
            if (s_push) begin
                chk("rr_order", s_grant, 4'b0001 << (k / MAX_BURST));
                k++;
            end
        end
        chk("rr_words", k, 16);

        // Owner 1 stalled by full FIFO for 5 cycles after two words.
        drive(1'b1, 4'b0000, 1'b0);
        step();
        drive(1'b0, 4'b0010, 1'b0);
        step();
        chk("stall_bubble", s_busy, 1'b0);
        for (int c = 0; c < 2; c++) begin
            step();
            chk("stall_pre_push", s_push, 1'b1);
        end
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 4'b0010, 1'b1);
            step();
            chk("stall_push",  s_push,  1'b0);
            chk("stall_ready", s_ready, 4'b0000);
            chk("stall_grant", s_grant, 4'b0010);
        end
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 4'b0010, 1'b0);
            step();
            chk("stall_post_push", s_push, 1'b1);
        end
        step();
        chk("stall_release", s_busy, 1'b0);

        // Reset mid-burst of owner 3, then requester 0 wins first.
        drive(1'b1, 4'b0000, 1'b0);
        step();
        drive(1'b0, 4'b1000, 1'b0);
        step();
        step();
        chk("rst_mid_push", s_push, 1'b1);
        drive(1'b1, 4'b1000, 1'b0);
        step();
        drive(1'b0, 4'b1001, 1'b0);
        step();
        chk("rst_mid_idle", s_grant, 4'b0000);
        step();
        chk("rst_first_grant", s_grant, 4'b0001);

        // Randomized traffic against the model.
        pushes = 0;
        for (int c = 0; c < 600; c++) begin
            logic [NUM_REQ-1:0] v;
            for (int i = 0; i < NUM_REQ; i++) v[i] = ($urandom_range(0, 3) != 0);
            drive(($urandom_range(0, 63) == 0), v, ($urandom_range(0, 4) == 0));
            step();
            if (s_push) pushes++;
        end
        drive(1'b0, '0, 1'b0);
        step();
        chk("sb_drain", exp_q.size(), 0);

`ifdef FIFO_ARB_STATS_EN
        for (int i = 0; i < NUM_REQ; i++)
            chk("stat_cnt", stat_cnt[i*16 +: 16], m_stat[i]);
        chk("stall_cnt", stall_cnt, m_stall);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Round-robin, burst-locking arbiter that shares the single push port of a synchronous FIFO among NUM_REQ producers.
- Each producer uses a valid/ready handshake. The block drives the FIFO push_en/fifo_din and back-pressures on the FIFO full flag.
- Sits directly in front of the FIFO instance. The FIFO pop side is untouched.

Parameters:
- DATA_W, 32, width of each requester word and of the FIFO data.
- NUM_REQ, 4, number of requesters (2..16).
- MAX_BURST, 4, maximum words one owner may push before the grant is released (1..255).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- req_valid  input  NUM_REQ  per-requester word valid
- req_data  input  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  output  NUM_REQ  per-requester accept
- fifo_full  input  1  full flag from the FIFO
- push_en  output  1  FIFO push strobe
- fifo_din  output  DATA_W  FIFO write data
- grant  output  NUM_REQ  one-hot current owner; all zero in IDLE
- busy  output  1  high in GRANT state

Behaviour:
- Reset is synchronous on rst. Values after reset:
  - state=IDLE, owner=0, last_owner=NUM_REQ-1 (requester 0 wins first), burst_cnt=0
  - grant=0, busy=0, push_en=0, req_ready=0, fifo_din=0
- A transfer occurs in a cycle where state==GRANT, req_valid[owner]==1 and fifo_full==0.
- FSM states:
  - IDLE: if req_valid!=0, the winner is the first set bit searching upward (with wrap) from last_owner+1. At the next edge: owner<=winner, burst_cnt<=0, state<=GRANT. Otherwise stay in IDLE. There is exactly one bubble cycle per arbitration.
  - GRANT: owner holds the grant while req_valid[owner]==1 and burst_cnt<MAX_BURST.
- Outputs in GRANT (combinational from registered owner/state):
  - req_ready[owner] = !fifo_full; all other req_ready bits = 0.
  - push_en = req_valid[owner] & !fifo_full.
  - fifo_din = req_data[owner]. fifo_din = 0 when not in GRANT.
- Each transfer increments burst_cnt. burst_cnt is $clog2(MAX_BURST+1) bits wide and never wraps.
- Release from GRANT to IDLE, with last_owner<=owner:
  - (a) a transfer occurs with burst_cnt==MAX_BURST-1, or
  - (b) req_valid[owner]==0 in a GRANT cycle.
- fifo_full high in GRANT:
  - Grant is held, no transfer, burst_cnt unchanged.
  - A stall never triggers release unless valid also drops.
- Requesters must hold req_valid/req_data stable until ready. Dropping valid early releases the grant; no word is lost because no transfer occurred.
- Non-owners are never acknowledged, even if the FIFO has space.
- Round-robin fairness: with all requesters continuously valid, grant order is 0,1,2,...,NUM_REQ-1,0,... Each owner pushes MAX_BURST words.
- rst asserted mid-burst: state returns to IDLE next edge and push_en=0 from that edge. Reset of the FIFO contents is handled by the FIFO's own rst.

Optional Feature:
- Macro FIFO_ARB_STATS_EN.
- When defined:
  - Adds output stat_cnt (NUM_REQ*16 bits): one 16-bit saturating counter per requester, counting accepted words.
  - Adds output stall_cnt (16 bits): counts GRANT cycles with req_valid[owner]==1 and fifo_full==1, saturating.
  - All counters clear on rst. Saturation value is 16'hFFFF.
- When undefined: these ports and counters do not exist. Arbitration behaviour is identical.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum (IDLE=1'b0, GRANT=1'b1)
  - function rr_next(req, last) returning winner index
  - localparam BCNT_W=$clog2(MAX_BURST+1) formula note
- One natural sub-module: rr_pick, the combinational round-robin priority picker (req vector, last index -> winner index, any).
- Top = FSM, burst counter, data mux.

Test Plan:
- Reset then req_valid=4'b0000 for 10 cycles -> grant=0, push_en=0, busy=0 throughout.
- req_valid=4'b1111, fifo_full=0, MAX_BURST=4 -> owner sequence 0,1,2,3,0; 4 pushes each; one idle bubble between bursts; 16 words in 20 cycles.
- Owner 2 valid for 2 words then drops -> release after 2 pushes; next grant goes to 3 if valid, else wraps to 0.
- fifo_full=1 for 5 cycles mid-burst of owner 1 (burst_cnt=2) -> push_en=0 and req_ready=0 for 5 cycles, grant held; burst completes 2 more words after full drops.
- rst pulsed during burst of owner 3 (burst_cnt=1) -> next cycle IDLE, grant=0; first grant after reset goes to requester 0.
- FIFO_ARB_STATS_EN defined, requester 0 pushes 70000 words -> stat_cnt[0]=16'hFFFF, no wrap; stall_cnt matches the number of injected full cycles.
